my_i2c_axil: RTL and testbench
==============================

# my_i2c_axil

AXI4-Lite slave exposing a register file and a single-master I2C write engine. Software loads a 7-bit device address, an 8-bit sub-address and a payload length, then writes a start register. The engine issues START, address+W, sub-address, N data bytes and STOP on open-drain SCL/SDA. It sits between the PS AXI interconnect and the board I2C pins, which connect through IOBUF primitives.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, AXI byte address width; 16 word registers.
- C_CLK_DIV, 250, clock cycles per SCL quarter-period (100 MHz gives 100 kHz).

Ports:
- s00_axi_aclk  in  1  sole clock.
- s00_axi_areset  in  1  asynchronous, active-high reset.
- s00_axi_aw{addr,prot,valid}/awready, w{data,strb,valid}/wready, b{resp,valid}/bready, ar{addr,prot,valid}/arready, r{data,resp,valid}/rready  AXI4-Lite slave; widths 6/3/1, 32/4/1, 2/1/1, 6/3/1, 32/2/1.
- my_scl_i / my_sda_i  in  1  pin sense.
- my_scl_o / my_sda_o  out  1  constant 0.
- my_scl_t / my_sda_t  out  1  1 = released (high-Z), 0 = drive low.
- dbg2_i2c_write_en  out  1  one-cycle pulse on an accepted start.
- dbg2_busy  out  1  transaction in progress.
- dbg2_req_data_chunk  out  1  the next data byte is needed in REG3.
- dbg2_nack  out  1  sticky NACK flag.

## Operation
- Register index = addr[5:2]. Writes honour wstrb per byte. bresp and rresp are always 0.
- REG0: device address [6:0], RW.
- REG1: sub-address [7:0], RW.
- REG2: length [7:0], RW.
- REG3: data byte [7:0], RW. Any write clears req_data_chunk.
- REG4: status, RO, {29'b0, req_data_chunk, nack, busy}.
- REG5: 32-bit scratch, RW.
- REG6: reserved, reads 0.
- REG7: start. A write with busy=0 launches a transaction; a write with busy=1 is ignored. Reads return 0.
- REG8–15: read 0; writes are ignored.
- FSM states: IDLE → START → ADDR (addr<<1 | 0) → ACK1 → SUB → ACK2 → [DATA → ACKn] × length → STOP → IDLE.
- On entering DATA, the byte is loaded from REG3 and req_data_chunk is set.
- For the second and later bytes, the FSM waits with SCL held low until req_data_chunk is 0.
- Length 0 goes directly from ACK2 to STOP.
- If SDA is sampled high in any ACK slot: set nack, go to STOP, then IDLE. nack clears on the next accepted start.
- busy is 1 from the cycle after the REG7 write until STOP completes.
- Bits go out MSB first. SDA changes only while SCL is low. The master releases SDA during ACK slots.

## Timing
- Reset values:
  - all registers 0; FSM in IDLE; busy, nack and req_data_chunk 0;
  - scl_t = sda_t = 1;
  - awready, wready, bvalid, arready, rvalid all 0;
  - rdata = 0.
- AXI write:
  - awready and wready pulse high together for one cycle when awvalid && wvalid && !awready && !bvalid.
  - The register updates on that same edge.
  - bvalid rises on the next cycle and holds until bready.
- AXI read:
  - arready pulses for one cycle when arvalid && !arready && !rvalid.
  - rvalid and rdata follow on the next cycle and hold until rready.
  - Holding arvalid high while rvalid is high does not generate a second read.
- Each SCL bit is 4 phases of C_CLK_DIV cycles: SCL low/SDA set, SCL rise, SCL high/sample, SCL fall.
- START: SDA falls while SCL is high, one phase before SCL falls.
- STOP: SDA rises one phase after SCL rises.
- Reset mid-transfer releases both lines immediately.

## Configuration
- MY_I2C_CLK_STRETCH_EN defined: after releasing SCL, the high phase counter does not advance until my_scl_i reads 1 (slave clock stretching).
- MY_I2C_CLK_STRETCH_EN undefined: my_scl_i is ignored and timing is purely counter-based.

## Test plan
- Write 0xABCD to REG5 with wstrb=0011, then read REG5 → rdata 0x0000ABCD, bresp=0, rresp=0.
- Write REG0=0x5B, REG1=0x00, REG2=0, then REG7; slave ACKs (SDA low) → bytes 0xB6 and 0x00 sent, then STOP; busy returns to 0; nack=0.
- REG2=2, REG3=0x11, start; after req_data_chunk rises write REG3=0x22 → bytes 0xB6, 0x00, 0x11, 0x22 sent; SCL held low until the REG3 write.
- No slave (SDA pulled high) → nack=1 after the address byte, then STOP; REG4 reads 0x2.
- Write REG7 while busy → ignored; the single transaction completes unchanged.
- Assert reset mid-byte → scl_t = sda_t = 1; busy=0; all registers 0.

Source files
------------

// File: rtl/my_i2c_axil_if.sv
// AXI4-Lite bus bundle between the PS interconnect and my_i2c_axil.
interface my_i2c_axil_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/my_i2c_axil.sv
// AXI4-Lite register file driving a single-master I2C write engine
// (START, addr+W, sub-address, N data bytes, STOP) on open-drain SCL/SDA.
// Optional feature: define MY_I2C_CLK_STRETCH_EN to honour slave clock stretching.
module my_i2c_axil #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned C_CLK_DIV          = 250
) (
  input  logic         s00_axi_aclk,
  input  logic         s00_axi_areset,
  my_i2c_axil_if.slave s00_axi,
  input  logic         my_scl_i,
  input  logic         my_sda_i,
  output logic         my_scl_o,
  output logic         my_scl_t,
  output logic         my_sda_o,
  output logic         my_sda_t,
  output logic         dbg2_i2c_write_en,
  output logic         dbg2_busy,
  output logic         dbg2_req_data_chunk,
  output logic         dbg2_nack
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DIV_W = $clog2(C_CLK_DIV + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_SUB, S_ACK2, S_WAIT, S_DATA, S_ACKN, S_STOP
  } state_t;

  // AXI handshake state
  logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [3:0]    rd_idx_q;

  // register file
  logic [6:0]    reg0_q;
  logic [7:0]    reg1_q, reg2_q, reg3_q;
  logic [DW-1:0] reg5_q;

  // engine state
  state_t          state_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]      phase_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      len_q;
  logic            sda_smp_q;
  logic            busy_q, nack_q, req_q, we_q;
  logic            scl_t_q, sda_t_q, scl_t_d, sda_t_d;

  logic       wr_fire, rd_fire, start_acc, tick, stall;
  logic [3:0] wr_idx;

  assign wr_idx    = 4'(s00_axi.awaddr[AW-1:2]);
  assign wr_fire   = s00_axi.awvalid && s00_axi.wvalid && !awready_q && !bvalid_q;
  assign rd_fire   = s00_axi.arvalid && !arready_q && !rvalid_q;
  assign start_acc = wr_fire && (wr_idx == 4'd7) && !busy_q;
  assign tick      = (div_q == DIV_W'(C_CLK_DIV - 1)) && !stall;

`ifdef MY_I2C_CLK_STRETCH_EN
  // hold the high phase while a slave keeps SCL low
  assign stall = (phase_q == 2'd2) && !my_scl_i && (state_q != S_START);
`else
  logic unused_scl;
  assign stall      = 1'b0;
  assign unused_scl = my_scl_i;
`endif

  logic unused_axi;
  assign unused_axi = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = 2'b00;

  assign my_scl_o            = 1'b0;
  assign my_sda_o            = 1'b0;
  assign my_scl_t            = scl_t_q;
  assign my_sda_t            = sda_t_q;
  assign dbg2_i2c_write_en   = we_q;
  assign dbg2_busy           = busy_q;
  assign dbg2_req_data_chunk = req_q;
  assign dbg2_nack           = nack_q;

  // read-data mux for the latched read index
  always_comb begin
    rdata_d = '0;
    case (rd_idx_q)
      4'd0:    rdata_d = DW'(reg0_q);
      4'd1:    rdata_d = DW'(reg1_q);
      4'd2:    rdata_d = DW'(reg2_q);
      4'd3:    rdata_d = DW'(reg3_q);
      4'd4:    rdata_d = DW'({req_q, nack_q, busy_q});
      4'd5:    rdata_d = reg5_q;
      default: rdata_d = '0;
    endcase
  end

  // line levels for the current state/phase; 1 = released
  always_comb begin
    scl_t_d = 1'b1;
    sda_t_d = 1'b1;
    case (state_q)
      S_START: begin
        scl_t_d = (phase_q < 2'd2);
        sda_t_d = (phase_q == 2'd0);
      end
      S_ADDR, S_SUB, S_DATA: begin
        scl_t_d = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_t_d = shift_q[7];
      end
      S_ACK1, S_ACK2, S_ACKN: begin
        scl_t_d = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_t_d = 1'b1;
      end
      S_WAIT: begin
        scl_t_d = 1'b0;
        sda_t_d = 1'b1;
      end
      S_STOP: begin
        scl_t_d = (phase_q != 2'd0);
        sda_t_d = phase_q[1];
      end
      default: ;
    endcase
  end

  // AXI write/read channel handshakes
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rd_idx_q  <= '0;
    end else begin
      awready_q <= wr_fire;
      wready_q  <= wr_fire;
      if (awready_q)            bvalid_q <= 1'b1;
      else if (s00_axi.bready)  bvalid_q <= 1'b0;
      arready_q <= rd_fire;
      if (rd_fire) rd_idx_q <= 4'(s00_axi.araddr[AW-1:2]);
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (s00_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // register writes and the I2C byte engine
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      reg0_q    <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      reg3_q    <= '0;
      reg5_q    <= '0;
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      len_q     <= '0;
      sda_smp_q <= 1'b0;
      busy_q    <= 1'b0;
      nack_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      scl_t_q   <= 1'b1;
      sda_t_q   <= 1'b1;
    end else begin
      we_q    <= 1'b0;
      scl_t_q <= scl_t_d;
      sda_t_q <= sda_t_d;

      if (wr_fire) begin
        case (wr_idx)
          4'd0: if (s00_axi.wstrb[0]) reg0_q <= s00_axi.wdata[6:0];
          4'd1: if (s00_axi.wstrb[0]) reg1_q <= s00_axi.wdata[7:0];
          4'd2: if (s00_axi.wstrb[0]) reg2_q <= s00_axi.wdata[7:0];
          4'd3: begin
            if (s00_axi.wstrb[0]) reg3_q <= s00_axi.wdata[7:0];
            req_q <= 1'b0;
          end
          4'd5: begin
            for (int i = 0; i < int'(DW / 8); i++) begin
              if (s00_axi.wstrb[i]) reg5_q[8*i +: 8] <= s00_axi.wdata[8*i +: 8];
            end
          end
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          div_q   <= '0;
          phase_q <= '0;
          if (start_acc) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
            we_q    <= 1'b1;
            nack_q  <= 1'b0;
            req_q   <= 1'b0;
            len_q   <= reg2_q;
          end
        end

        // SCL stays low until software refills REG3
        S_WAIT: begin
          div_q   <= '0;
          phase_q <= '0;
          if (!req_q) begin
            state_q <= S_DATA;
            shift_q <= reg3_q;
            req_q   <= 1'b1;
            len_q   <= len_q - 8'd1;
            bit_q   <= '0;
          end
        end

        default: begin
          if (!stall) div_q <= tick ? '0 : div_q + 1'b1;
          if (tick) begin
            phase_q <= phase_q + 2'd1;
            if (phase_q == 2'd2) sda_smp_q <= my_sda_i;
            if (phase_q == 2'd3) begin
              case (state_q)
                S_START: begin
                  state_q <= S_ADDR;
                  shift_q <= {reg0_q, 1'b0};
                  bit_q   <= '0;
                end
                S_ADDR, S_SUB, S_DATA: begin
                  if (bit_q == 3'd7) begin
                    bit_q   <= '0;
                    state_q <= (state_q == S_ADDR) ? S_ACK1 :
                               (state_q == S_SUB)  ? S_ACK2 : S_ACKN;
                  end else begin
                    bit_q   <= bit_q + 3'd1;
                    shift_q <= {shift_q[6:0], 1'b0};
                  end
                end
                S_ACK1: begin
                  if (sda_smp_q) begin
                    nack_q  <= 1'b1;
                    state_q <= S_STOP;
                  end else begin
                    state_q <= S_SUB;
                    shift_q <= reg1_q;
                  end
                end
                S_ACK2, S_ACKN: begin
                  if (sda_smp_q) begin
                    nack_q  <= 1'b1;
                    state_q <= S_STOP;
                  end else if (len_q == 8'd0) begin
                    state_q <= S_STOP;
                  end else if (state_q == S_ACKN && req_q) begin
                    state_q <= S_WAIT;
                  end else begin
                    state_q <= S_DATA;
                    shift_q <= reg3_q;
                    req_q   <= 1'b1;
                    len_q   <= len_q - 8'd1;
                  end
                end
                S_STOP: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_i2c_axil.sv
// Scoreboard bench for my_i2c_axil: AXI master tasks, an I2C slave model,
// and monitors that pop expected read data and I2C bytes from queues.
module tb_my_i2c_axil;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  my_i2c_axil_if #(.ADDR_W(6), .DATA_W(32)) axi ();

  logic scl_t, sda_t, scl_o, sda_o, we, busy, req, nack;
  logic slave_low = 1'b0;
  wire  scl_line = scl_t;
  wire  sda_line = sda_t & ~slave_low;

  my_i2c_axil #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .C_CLK_DIV(DIV)) dut (
    .s00_axi_aclk        (clk),
    .s00_axi_areset      (rst),
    .s00_axi             (axi),
    .my_scl_i            (scl_line),
    .my_sda_i            (sda_line),
    .my_scl_o            (scl_o),
    .my_scl_t            (scl_t),
    .my_sda_o            (sda_o),
    .my_sda_t            (sda_t),
    .dbg2_i2c_write_en   (we),
    .dbg2_busy           (busy),
    .dbg2_req_data_chunk (req),
    .dbg2_nack           (nack)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_exp_q[$];
  logic [7:0]  byte_exp_q[$];
  int  sl_bit = 0;
  logic [7:0] sl_sr = '0;
  bit  ack_en = 1'b1;
  int  bytes_seen = 0;
  int  stops_seen = 0;
  int  we_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // I2C slave: START/STOP detection
  always @(negedge sda_line) if (scl_line === 1'b1) sl_bit = 0;
  always @(posedge sda_line) if (scl_line === 1'b1) stops_seen++;

  // I2C slave: shift in data bits and score each completed byte
  always @(posedge scl_line) begin
    if (sl_bit < 8) begin
      sl_sr = {sl_sr[6:0], sda_line};
      sl_bit++;
      if (sl_bit == 8) begin
        bytes_seen++;
        if (byte_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL i2c_byte_unexpected: got 0x%02h expected none", sl_sr);
        end else begin
          check("i2c_byte", 32'(sl_sr), 32'(byte_exp_q.pop_front()));
        end
      end
    end
  end

  // I2C slave: drive the ACK slot
  always @(negedge scl_line) begin
    if (sl_bit == 8) begin
      slave_low = ack_en;
      sl_bit = 9;
    end else if (sl_bit == 9) begin
      slave_low = 1'b0;
      sl_bit = 0;
    end
  end

  // AXI response monitor and start-pulse counter
  always @(negedge clk) begin
    if (!rst) begin
      if (axi.rvalid && axi.rready) begin
        if (rd_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL axi_read_unexpected: got 0x%08h expected none", axi.rdata);
        end else begin
          check("axi_rdata", axi.rdata, rd_exp_q.pop_front());
        end
        check("axi_rresp", 32'(axi.rresp), 32'd0);
      end
      if (axi.bvalid && axi.bready) check("axi_bresp", 32'(axi.bresp), 32'd0);
      if (we) we_cnt++;
    end
  end

  task automatic axi_write(input logic [3:0] idx, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    axi.awaddr  = {idx, 2'b00};
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.awready && n < 50);
    if (!axi.awready) begin
      checks++;
      errors++;
      $display("FAIL aw_timeout: got awready 0 expected 1");
    end
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic axi_read(input logic [3:0] idx, input logic [31:0] exp);
    int n;
    rd_exp_q.push_back(exp);
    @(posedge clk); #1;
    axi.araddr  = {idx, 2'b00};
    axi.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 50);
    if (!axi.arready) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout: got arready 0 expected 1");
    end
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (bytes_seen < target && n < 3000) begin @(negedge clk); n++; end
    check("bytes_arrive", 32'(bytes_seen >= target), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stops0, we0, hi, b0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;

    // reset state
    #1 rst = 1'b1;
    #2;
    check("rst_scl_t", 32'(scl_t), 32'd1);
    check("rst_sda_t", 32'(sda_t), 32'd1);
    check("rst_flags", 32'({busy, nack, req}), 32'd0);
    check("rst_axi_hs", 32'({axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid}), 32'd0);
    check("rst_rdata", axi.rdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    sl_bit = 0; slave_low = 1'b0;

    // register file and strobes
    axi_write(4'd5, 32'h1234ABCD, 4'b0011);
    axi_read(4'd5, 32'h0000ABCD);
    axi_write(4'd5, 32'hEE000000, 4'b1000);
    axi_read(4'd5, 32'hEE00ABCD);
    axi_write(4'd0, 32'hFFFFFFFF, 4'b1111);
    axi_read(4'd0, 32'h0000007F);
    axi_write(4'd9, 32'hFFFFFFFF, 4'b1111);
    axi_read(4'd9, 32'h0);
    axi_write(4'd6, 32'hFFFFFFFF, 4'b1111);
    axi_read(4'd6, 32'h0);
    axi_read(4'd7, 32'h0);
    axi_read(4'd4, 32'h0);

    // zero-length write: address and sub-address only
    axi_write(4'd0, 32'h5B, 4'b0001);
    axi_write(4'd1, 32'h00, 4'b0001);
    axi_write(4'd2, 32'h00, 4'b0001);
    byte_exp_q.push_back(8'hB6);
    byte_exp_q.push_back(8'h00);
    stops0 = stops_seen;
    axi_write(4'd7, 32'h1, 4'b0001);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_idle();
    check("t2_bytes_done", 32'(byte_exp_q.size()), 32'd0);
    check("t2_stop", 32'(stops_seen - stops0), 32'd1);
    check("t2_nack", 32'(nack), 32'd0);
    axi_read(4'd4, 32'h0);

    // two data bytes with a software refill between them
    axi_write(4'd2, 32'h02, 4'b0001);
    axi_write(4'd3, 32'h11, 4'b0001);
    b0 = bytes_seen;
    byte_exp_q.push_back(8'hB6);
    byte_exp_q.push_back(8'h00);
    byte_exp_q.push_back(8'h11);
    byte_exp_q.push_back(8'h22);
    axi_write(4'd7, 32'h1, 4'b0001);
    wait_bytes(b0 + 3);
    repeat (40) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (scl_t) hi++;
    end
    check("t3_scl_held_low", 32'(hi), 32'd0);
    check("t3_req", 32'(req), 32'd1);
    axi_read(4'd4, 32'h5);
    axi_write(4'd3, 32'h22, 4'b0001);
    wait_idle();
    check("t3_bytes_done", 32'(byte_exp_q.size()), 32'd0);

    // no slave: NACK after address byte
    axi_write(4'd3, 32'h00, 4'b0001);
    ack_en = 1'b0;
    byte_exp_q.push_back(8'hB6);
    stops0 = stops_seen;
    axi_write(4'd7, 32'h1, 4'b0001);
    wait_idle();
    check("t4_nack", 32'(nack), 32'd1);
    check("t4_stop", 32'(stops_seen - stops0), 32'd1);
    check("t4_bytes_done", 32'(byte_exp_q.size()), 32'd0);
    axi_read(4'd4, 32'h2);
    ack_en = 1'b1;

    // start while busy is ignored; new start clears nack
    axi_write(4'd2, 32'h00, 4'b0001);
    byte_exp_q.push_back(8'hB6);
    byte_exp_q.push_back(8'h00);
    we0 = we_cnt;
    stops0 = stops_seen;
    axi_write(4'd7, 32'h1, 4'b0001);
    check("t5_nack_cleared", 32'(nack), 32'd0);
    repeat (20) @(negedge clk);
    axi_write(4'd7, 32'h1, 4'b0001);
    wait_idle();
    check("t5_start_pulses", 32'(we_cnt - we0), 32'd1);
    check("t5_stop", 32'(stops_seen - stops0), 32'd1);
    check("t5_bytes_done", 32'(byte_exp_q.size()), 32'd0);

    // reset in the middle of the sub-address byte
    axi_write(4'd5, 32'hCAFEF00D, 4'b1111);
    b0 = bytes_seen;
    byte_exp_q.push_back(8'hB6);
    axi_write(4'd7, 32'h1, 4'b0001);
    wait_bytes(b0 + 1);
    repeat (28) @(negedge clk);
    check("t6_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("t6_scl_t", 32'(scl_t), 32'd1);
    check("t6_sda_t", 32'(sda_t), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    byte_exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    sl_bit = 0; slave_low = 1'b0;
    axi_read(4'd0, 32'h0);
    axi_read(4'd2, 32'h0);
    axi_read(4'd5, 32'h0);
    axi_read(4'd4, 32'h0);

    repeat (10) @(negedge clk);
    check("reads_drained", 32'(rd_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
